// File: rtl/flow_lii_packer.sv
// flow_lii_packer: packs PW/DW consecutive DW-bit flow words into one PW-bit
// LII flit (lane 0 first) and holds each flit in an output register until the
// interconnect accepts it. Frame ends (tlast) close partial flits, zero-padded.
//
// Optional build macro FLOW_LII_PACKER_TIMEOUT_EN adds an idle counter that
// flushes a partial flit after TIMEOUT idle cycles.
//
// Handshake: a beat transfers on a rising edge where valid && ready. Valid,
// once raised, holds with its data stable until that transfer; ready on the
// input side depends only on registered state and downstream ready.
module flow_lii_packer #(
  parameter int          PW      = 256,
  parameter int          DW      = 64,
  parameter logic [7:0]  SRC_ID  = 8'h02,
  parameter logic [7:0]  DST_ID  = 8'h00,
  parameter int          TIMEOUT = 64
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [DW-1:0] s_flow_tdata,
  input  logic          s_flow_tvalid,
  output logic          s_flow_tready,
  input  logic          s_flow_tlast,
  output logic [PW-1:0] lii_out_p0_tdata,
  output logic          lii_out_p0_tvalid,
  input  logic          lii_out_p0_tready,
  output logic [7:0]    lii_out_p0_src,
  output logic [7:0]    lii_out_p0_dst,
  output logic          frame_done,
  output logic [31:0]   flit_cnt
);

  localparam int K  = PW / DW;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = (K > 1) ? (K - 1) * DW : DW;

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] out_reg_q, out_reg_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          frame_done_q, frame_done_d;
  logic [31:0]   flit_cnt_q, flit_cnt_d;

  logic          accept;
  logic          drain;
  logic          complete;
  logic [PW-1:0] acc_ext;
  logic [PW-1:0] flit;

`ifdef FLOW_LII_PACKER_TIMEOUT_EN
  logic [15:0]   idle_q, idle_d;
  logic          flush;
`endif

  assign s_flow_tready     = !out_valid_q || lii_out_p0_tready;
  assign accept            = s_flow_tvalid && s_flow_tready;
  assign drain             = out_valid_q && lii_out_p0_tready;
  assign complete          = (cnt_q == CW'(K - 1)) || s_flow_tlast;
  // Accumulator widened to a full flit; the top lane is always zero.
  assign acc_ext           = PW'(acc_q);

  assign lii_out_p0_tdata  = out_reg_q;
  assign lii_out_p0_tvalid = out_valid_q;
  assign lii_out_p0_src    = SRC_ID;
  assign lii_out_p0_dst    = DST_ID;
  assign frame_done        = frame_done_q;
  assign flit_cnt          = flit_cnt_q;

  // Completed flit: stored lanes below cnt, incoming word at lane cnt, zeros above.
  always_comb begin
    flit = '0;
    for (int i = 0; i < K; i++) begin
      if (i < int'(cnt_q)) flit[i*DW +: DW] = acc_ext[i*DW +: DW];
      else if (i == int'(cnt_q)) flit[i*DW +: DW] = s_flow_tdata;
    end
  end

`ifdef FLOW_LII_PACKER_TIMEOUT_EN
  // Idle counter: cleared by accepted words and when empty, saturates at TIMEOUT.
  always_comb begin
    idle_d = idle_q;
    if (accept || cnt_q == '0) idle_d = '0;
    else if (idle_q < 16'(TIMEOUT)) idle_d = idle_q + 16'd1;
    flush = !accept && (cnt_q != '0) && (idle_q >= 16'(TIMEOUT)) &&
            (!out_valid_q || lii_out_p0_tready);
  end
`endif

  // Next state: output drain, word accumulation, flit load (and timeout flush).
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_reg_d    = out_reg_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = drain && out_last_q;
    flit_cnt_d   = flit_cnt_q;

    if (drain) begin
      flit_cnt_d  = flit_cnt_q + 32'd1;
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        out_reg_d   = flit;
        out_valid_d = 1'b1;
        out_last_d  = s_flow_tlast;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        for (int i = 0; i < K - 1; i++) begin
          if (i == int'(cnt_q)) acc_d[i*DW +: DW] = s_flow_tdata;
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
`ifdef FLOW_LII_PACKER_TIMEOUT_EN
    else if (flush) begin
      out_reg_d   = acc_ext;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      cnt_d       = '0;
      acc_d       = '0;
    end
`endif
  end

  // State registers with synchronous reset discarding partial and pending flits.
  always_ff @(posedge aclk) begin
    if (arst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_reg_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      flit_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_reg_q    <= out_reg_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      flit_cnt_q   <= flit_cnt_d;
    end
  end

`ifdef FLOW_LII_PACKER_TIMEOUT_EN
  // Idle counter register.
  always_ff @(posedge aclk) begin
    if (arst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`endif

endmodule

// File: doc/flow_lii_packer.md
Name: flow_lii_packer

Overview:
- Downstream neighbour of the optical-flow calc wrapper.
- Consumes the 64-bit flow-vector stream that the wrapper emits on its LII output lane.
- Packs PW/DW consecutive flow words into one PW-bit LII flit and tags it with fixed src/dst IDs for the interconnect.
- Handles partial flits at frame end. Its output register holds each flit stable under backpressure.

Parameters:
- PW, 256, LII packing width (bits); must be an integer multiple of DW.
- DW, 64, flow word width (bits).
- SRC_ID, 8'h02, constant driven on lii_out_p0_src.
- DST_ID, 8'h00, constant driven on lii_out_p0_dst.
- TIMEOUT, 64, idle cycles before a partial flit is flushed (used only with the optional feature; must be ≥1).

Ports:
- aclk, in, 1, clock; all logic is rising-edge.
- arst, in, 1, reset; synchronous, active-high.
- s_flow_tdata, in, DW, flow word.
- s_flow_tvalid, in, 1, word valid.
- s_flow_tready, out, 1, word accepted when tvalid&tready.
- s_flow_tlast, in, 1, last word of frame.
- lii_out_p0_tdata, out, PW, packed flit.
- lii_out_p0_tvalid, out, 1, flit valid.
- lii_out_p0_tready, in, 1, downstream ready.
- lii_out_p0_src, out, 8, = SRC_ID.
- lii_out_p0_dst, out, 8, = DST_ID.
- frame_done, out, 1, one-cycle pulse when the flit carrying tlast is accepted downstream.
- flit_cnt, out, 32, count of flits accepted downstream; wraps at 2^32.

Behaviour:
- K = PW/DW lanes. Lane i occupies tdata[i*DW +: DW]. Words fill lanes LSB-first: the first word of a flit goes in lane 0.
- State:
  - acc: K-1 lanes of data.
  - cnt: 0..K-1.
  - out_reg: PW bits.
  - out_valid.
  - out_last: this flit ends a frame.
- Reset (arst=1 at a clock edge):
  - cnt=0, acc=0, out_valid=0, out_last=0, frame_done=0, flit_cnt=0, out_reg=0.
  - Any partial flit and any pending output flit are discarded.
- s_flow_tready = !out_valid || lii_out_p0_tready. It depends only on registered state and downstream ready, never on s_flow_tvalid or s_flow_tlast.
- On accept with cnt<K-1 and tlast=0: word goes into acc lane cnt; cnt++.
- On accept with cnt==K-1, or with tlast=1:
  - out_reg = {word at lane cnt, acc lanes 0..cnt-1, zeros in lanes above cnt}.
  - out_valid=1; out_last=tlast; cnt=0; acc cleared.
  - Latency: completing word accepted at cycle N → tvalid high at N+1.
- tlast at cnt==K-1 produces exactly one flit; no empty trailing flit. tlast at cnt==0 produces a flit with lane 0 only and lanes 1..K-1 zero.
- Output handshake:
  - While out_valid && !lii_out_p0_tready, out_reg, out_valid and out_last hold stable.
  - On out_valid && tready: flit_cnt++; frame_done=out_last in the next cycle (one pulse); out_valid clears unless a new flit loads in the same cycle.
  - Simultaneous drain and load: the new flit replaces the old one with no bubble. Sustained throughput is 1 word/cycle when downstream is always ready.
- lii_out_p0_tdata = out_reg. src and dst are constant from the parameters, including during reset.

Optional Feature:
- Macro: FLOW_LII_PACKER_TIMEOUT_EN.
- With the macro:
  - A 16-bit idle counter resets on any accepted word, and also while cnt==0.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT with cnt>0 and out_valid==0 (or draining that cycle), acc lanes 0..cnt-1 flush as a zero-padded flit with out_last=0; cnt=0.
  - A flush is blocked while an undrained flit is pending. The counter saturates and the flush fires when the output frees up.
  - Flush and an accepted word never coincide, because an accepted word resets the counter.
- Without the macro: the counter is absent. Partial flits leave only on tlast or reset.

Test Plan:
- Reset, then 8 words 0x1..0x8 with tlast on 0x8 and ready=1 → two flits, {0x4,0x3,0x2,0x1} and {0x8,0x7,0x6,0x5} (lane3..lane0); tvalid one cycle after the 4th/8th word; frame_done pulses once; flit_cnt=2.
- 3 words 0xA,0xB,0xC with tlast on 0xC → one flit, lane0=0xA, lane1=0xB, lane2=0xC, lane3=0; frame_done=1.
- Hold lii_out_p0_tready=0 for 10 cycles after the first flit while streaming → tdata stable; s_flow_tready low once the next flit completes; no word lost or duplicated after ready returns; src=SRC_ID, dst=DST_ID throughout.
- Assert arst with cnt=2 and a flit pending → next cycle tvalid=0, flit_cnt=0; the following 4 words form a clean flit with no stale lanes.
- Continuous 400 words, ready=1 → 100 flits; s_flow_tready never deasserts; flit_cnt=100.
- With FLOW_LII_PACKER_TIMEOUT_EN, TIMEOUT=16: 2 words, then idle → after 16 idle cycles a flit {0,0,w1,w0} appears; frame_done stays 0.
